// File: rtl/uart_receiver.sv
// Purpose: UART receive stage (1 start, SIZE_DATA data LSB first, 1 stop, no parity) oversampled by i_stick.
// Latency: strobe/error pulse registered one cycle after the mid-stop sampling tick.
// Backpressure: none toward the line; a good frame arriving while i_fifo_full is set is dropped and flagged.
module uart_receiver #(
    parameter int SIZE_DATA   = 8,
    parameter int OVER_SAMPLE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stick,
    input  logic                 i_rx_serial,
    input  logic                 i_fifo_full,
    output logic [SIZE_DATA-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    localparam int CW = $clog2(OVER_SAMPLE) + 1;
    localparam int IW = (SIZE_DATA > 1) ? $clog2(SIZE_DATA) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(OVER_SAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVER_SAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(SIZE_DATA - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic                 rx_meta;
    logic                 rx_s;

    state_t               state,     state_n;
    logic [CW-1:0]        count,     count_n;
    logic [IW-1:0]        index,     index_n;
    logic [SIZE_DATA-1:0] shreg,     shreg_n;
    logic [SIZE_DATA-1:0] rx_data_n;
    logic                 rx_valid_n;
    logic                 frame_err_n;
    logic                 overrun_n;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx_serial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            count       <= '0;
            index       <= '0;
            shreg       <= '0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            index       <= index_n;
            shreg       <= shreg_n;
            o_rx_data   <= rx_data_n;
            o_rx_valid  <= rx_valid_n;
            o_frame_err <= frame_err_n;
            o_overrun   <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        count_n     = count;
        index_n     = index;
        shreg_n     = shreg;
        rx_data_n   = o_rx_data;
        rx_valid_n  = 1'b0;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;

        case (state)
            S_IDLE: begin
                count_n = '0;
                index_n = '0;
                if (!rx_s) begin
                    state_n = S_START;
                end
            end

            S_START: begin
                if (i_stick) begin
                    if (count == HALF_LAST) begin
                        count_n = '0;
                        state_n = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        count_n = count + CW'(1);
                    end
                end
            end

            S_DATA: begin
                if (i_stick) begin
                    if (count == FULL_LAST) begin
                        count_n = '0;
                        shreg_n = {rx_s, shreg[SIZE_DATA-1:1]};
                        if (index == IDX_LAST) begin
                            index_n = '0;
                            state_n = S_STOP;
                        end else begin
                            index_n = index + IW'(1);
                        end
                    end else begin
                        count_n = count + CW'(1);
                    end
                end
            end

            // Leave at mid-stop so a start bit immediately following is not missed.
            S_STOP: begin
                if (i_stick) begin
                    if (count == FULL_LAST) begin
                        count_n = '0;
                        if (rx_s) begin
                            state_n = S_IDLE;
                            if (i_fifo_full) begin
                                overrun_n = 1'b1;
                            end else begin
                                rx_valid_n = 1'b1;
                                rx_data_n  = shreg;
                            end
                        end else begin
                            frame_err_n = 1'b1;
                            state_n     = S_BREAK;
                        end
                    end else begin
                        count_n = count + CW'(1);
                    end
                end
            end

            S_BREAK: begin
                count_n = '0;
                index_n = '0;
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
                count_n = '0;
                index_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: OVER_SAMPLE=16, stick every 4 clocks, so one bit = 64 clocks.
module tb_uart_receiver;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_stick;
    logic       i_rx_serial;
    logic       i_fifo_full;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_frame_err;
    logic       o_overrun;

    int n_cmp  = 0;
    int n_bad  = 0;
    int nvalid = 0;
    int nferr  = 0;
    int novr   = 0;
    int nmulti = 0;
    logic [7:0] rx_q[$];

    localparam int BIT_CLKS = 64;

    uart_receiver #(.SIZE_DATA(8), .OVER_SAMPLE(16)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_stick     (i_stick),
        .i_rx_serial (i_rx_serial),
        .i_fifo_full (i_fifo_full),
        .o_rx_data   (o_rx_data),
        .o_rx_valid  (o_rx_valid),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        int sc;
        sc = 0;
        i_stick = 1'b0;
        forever begin
            @(negedge i_clk);
            i_stick = (sc == 3);
            sc = (sc + 1) % 4;
        end
    end

    // Pulse monitor: every high cycle is counted, so a stretched pulse shows up as an extra count.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_rx_valid) begin
                nvalid++;
                rx_q.push_back(o_rx_data);
            end
            if (o_frame_err) nferr++;
            if (o_overrun)   novr++;
            if ((32'(o_rx_valid) + 32'(o_frame_err) + 32'(o_overrun)) > 1) nmulti++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic send_bit(input logic b);
        i_rx_serial = b;
        idle(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_bit);
    endtask

    function automatic logic [7:0] q_at(input int k);
        if (rx_q.size() > k) return rx_q[k];
        return 8'hxx;
    endfunction

    initial begin
        i_rst_n     = 1'b0;
        i_rx_serial = 1'b1;
        i_fifo_full = 1'b0;
        idle(3);
        check("reset_data",  32'(o_rx_data),   32'h0);
        check("reset_valid", 32'(o_rx_valid),  32'h0);
        check("reset_ferr",  32'(o_frame_err), 32'h0);
        check("reset_ovr",   32'(o_overrun),   32'h0);
        i_rst_n = 1'b1;
        idle(100);

        send_frame(8'hA5, 1'b1);
        idle(64);
        check("a5_count", nvalid, 1);
        check("a5_data",  32'(o_rx_data), 32'hA5);
        check("a5_ferr",  nferr, 0);
        check("a5_ovr",   novr, 0);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(64);
        check("b2b_count", nvalid, 4);
        check("b2b_d0", 32'(q_at(1)), 32'h00);
        check("b2b_d1", 32'(q_at(2)), 32'hFF);
        check("b2b_d2", 32'(q_at(3)), 32'h3C);

        i_rx_serial = 1'b0;
        idle(20);
        i_rx_serial = 1'b1;
        idle(200);
        check("glitch_count", nvalid, 4);
        send_frame(8'h81, 1'b1);
        idle(64);
        check("g81_count", nvalid, 5);
        check("g81_data",  32'(o_rx_data), 32'h81);

        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'(8'h55 >> i));
        i_rx_serial = 1'b0;
        idle(160);
        i_rx_serial = 1'b1;
        idle(128);
        check("ferr_count",  nferr, 1);
        check("ferr_valid",  nvalid, 5);
        check("ferr_data",   32'(o_rx_data), 32'h81);
        send_frame(8'h12, 1'b1);
        idle(64);
        check("f12_count", nvalid, 6);
        check("f12_data",  32'(o_rx_data), 32'h12);

        i_fifo_full = 1'b1;
        send_frame(8'h77, 1'b1);
        idle(64);
        i_fifo_full = 1'b0;
        check("ovr_count", novr, 1);
        check("ovr_valid", nvalid, 6);
        check("ovr_data",  32'(o_rx_data), 32'h12);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i));
        i_rx_serial = 1'(8'hC3 >> 4);
        idle(20);
        #1 i_rst_n = 1'b0;
        #1;
        check("mrst_data",  32'(o_rx_data),   32'h0);
        check("mrst_valid", 32'(o_rx_valid),  32'h0);
        check("mrst_ferr",  32'(o_frame_err), 32'h0);
        check("mrst_ovr",   32'(o_overrun),   32'h0);
        i_rx_serial = 1'b1;
        idle(5);
        i_rst_n = 1'b1;
        idle(128);
        check("mrst_nopulse", nvalid + nferr + novr, 8);
        send_frame(8'h5A, 1'b1);
        idle(64);
        check("f5a_count", nvalid, 7);
        check("f5a_data",  32'(o_rx_data), 32'h5A);
        check("final_ferr", nferr, 1);
        check("final_ovr",  novr, 1);
        check("exclusive",  nmulti, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART receive stage sitting directly downstream of the serial transmitter: it consumes the 1-start / SIZE_DATA-data (LSB first) / 1-stop serial stream, oversampled by the same baud tick `i_stick`, and delivers each received byte as a one-cycle write pulse into the RX FIFO. It flags framing errors (stop bit low) and overruns (byte completed while RX FIFO full). Framing is no-parity, one stop bit, matching the transmitter.

## Interface
- SIZE_DATA, 8, data bits per frame
- OVER_SAMPLE, 16, `i_stick` ticks per bit period; even, ≥ 4

- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low; one clock, all flops reset asynchronously
- i_stick  in  1  oversample tick, one-cycle pulse, OVER_SAMPLE per bit
- i_rx_serial  in  1  asynchronous serial line, idle high
- i_fifo_full  in  1  RX FIFO full
- o_rx_data  out  SIZE_DATA  last received byte, registered, held until next good frame
- o_rx_valid  out  1  one-cycle write strobe to RX FIFO
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_overrun  out  1  one-cycle pulse: good frame dropped because FIFO full

## Operation
- Input sync: `i_rx_serial` passes through 2 flops (reset value 1) → `rx_s`. All decisions use `rx_s` only.
- Counters: `count` ($clog2(OVER_SAMPLE)+1 bits) increments only on `i_stick`; `index` counts data bits 0..SIZE_DATA-1; shift register `shreg` SIZE_DATA bits, shifts right, new bit into MSB (LSB-first reconstruction).
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: count=0, index=0. `rx_s==0` → START.
- START: on `i_stick` with count==OVER_SAMPLE/2-1 (mid start bit): if `rx_s==0` → DATA, count=0; else glitch → IDLE, no outputs. Otherwise count += i_stick.
- DATA: on `i_stick` with count==OVER_SAMPLE-1: shreg ← {rx_s, shreg[SIZE_DATA-1:1]}, count=0; if index==SIZE_DATA-1 → STOP, index=0, else index+1.
- STOP: on `i_stick` with count==OVER_SAMPLE-1 (mid stop bit):
  - rx_s==1, i_fifo_full==0: o_rx_data ← shreg, o_rx_valid pulse → IDLE.
  - rx_s==1, i_fifo_full==1: o_overrun pulse, o_rx_data unchanged, no strobe → IDLE.
  - rx_s==0: o_frame_err pulse, o_rx_data unchanged, no strobe → BREAK.
- BREAK: wait for rx_s==1 → IDLE (prevents a held-low line/break from being re-read as frames).
- Returning to IDLE at mid-stop (not end of stop) is required so back-to-back frames from the transmitter are not missed.
- Illegal state encoding → IDLE next cycle.

## Timing
- Reset values: o_rx_data=0, o_rx_valid=0, o_frame_err=0, o_overrun=0, state=IDLE, sync flops=1.
- Falling edge on `i_rx_serial` → START entry 2 cycles (sync) + 1 cycle.
- Data bit k sampled at OVER_SAMPLE/2 + (k+1)·OVER_SAMPLE ticks after start detection; stop at OVER_SAMPLE/2 + (SIZE_DATA+1)·OVER_SAMPLE.
- o_rx_valid / o_frame_err / o_overrun registered: asserted the cycle after the sampling stick edge, exactly one cycle; mutually exclusive.
- o_rx_data updates in the same cycle o_rx_valid asserts.
- i_fifo_full sampled only at the stop-sample cycle.
- i_stick low: all counters hold; state advance requires sampling-tick conditions as above.
- Reset mid-frame: immediate return to reset values; partial byte discarded, no pulse.

## Test plan
- OVER_SAMPLE=16, i_stick every 4 cycles, transmitter-style frame of 0xA5 → one o_rx_valid pulse, o_rx_data=0xA5, no error pulses.
- Back-to-back frames 0x00, 0xFF, 0x3C with zero idle gap → three o_rx_valid pulses, data in order, none dropped.
- Start glitch: line low for 5 sticks then high → returns to IDLE, no pulse; following valid frame 0x81 received correctly.
- Frame 0x55 with stop bit forced 0, line held low 40 sticks then high → one o_frame_err, no o_rx_valid, o_rx_data unchanged; next frame 0x12 received.
- i_fifo_full=1 during frame 0x77 → o_overrun pulse, no o_rx_valid, o_rx_data keeps prior 0x12.
- Assert i_rst_n=0 at data bit 4 of frame 0xC3 → outputs 0 immediately; after release, frame 0x5A received as 0x5A.
